// File: rtl/obsidian_fetch.sv
// rtl/obsidian_fetch.sv - instruction fetch unit: PC, imem read issue, 2-entry buffer to decode
// Optional feature macro: OBSIDIAN_ALIGN_CHECK_EN (misaligned redirect target raises a
// sticky fetch_fault and halts issue until reset).
`timescale 1ns/1ps

module obsidian_fetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [31:0]       i_imem_rdata,
    output logic [31:0]       o_instruction,
    output logic [ADDR_W-1:0] o_instr_pc,
    output logic              o_instr_valid,
    input  logic              i_instr_ready,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_fetch_fault
);

    // Fetch PC and the epoch that tags reads so stale returns can be recognised.
    logic [ADDR_W-1:0] r_pc;
    logic              r_epoch;

    // The single read that may be in flight (memory answers one cycle after the strobe).
    logic              r_out_valid;
    logic              r_out_epoch;
    logic [ADDR_W-1:0] r_out_pc;

    // Two-entry buffer of {pc, instruction}; head feeds decode.
    logic [31:0]       r_fifo_instr [2];
    logic [ADDR_W-1:0] r_fifo_pc    [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_count;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_halt;
    logic [1:0]        w_level;
    logic [ADDR_W-1:0] w_target;

    assign w_pop    = o_instr_valid & i_instr_ready;

    // Occupancy after this cycle's pop, plus the slot reserved by the read in flight.
    // Counting the pop lets a fully-ready decode stream one instruction per cycle.
    assign w_level  = r_count - {1'b0, w_pop} + {1'b0, r_out_valid};
    assign w_issue  = !i_reset && !i_redirect && !w_halt && (w_level < 2'd2);

    // A returning read is kept only if no redirect happened since it was issued.
    assign w_push   = r_out_valid && (r_out_epoch == r_epoch) && !i_redirect;

    // Word-aligned redirect target; the low bits never reach the PC.
    assign w_target = {i_redirect_pc[ADDR_W-1:2], 2'b00};

    assign o_imem_req    = w_issue;
    assign o_imem_addr   = r_pc;
    assign o_instr_valid = (r_count != 2'd0);
    assign o_instruction = r_fifo_instr[r_rd_ptr];
    assign o_instr_pc    = r_fifo_pc[r_rd_ptr];

    // PC, in-flight tracking and buffer update; redirect flushes everything but the
    // handshake already completing this cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc        <= RESET_PC;
            r_epoch     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_epoch <= 1'b0;
            r_out_pc    <= '0;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_count     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else begin
            r_out_valid <= w_issue;
            if (w_issue) begin
                r_out_pc    <= r_pc;
                r_out_epoch <= r_epoch;
                r_pc        <= r_pc + ADDR_W'(4);
            end
            if (i_redirect) begin
                r_pc     <= w_target;
                r_epoch  <= ~r_epoch;
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
                r_count  <= 2'd0;
            end else begin
                if (w_push) begin
                    r_fifo_instr[r_wr_ptr] <= i_imem_rdata;
                    r_fifo_pc[r_wr_ptr]    <= r_out_pc;
                    r_wr_ptr               <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

`ifdef OBSIDIAN_ALIGN_CHECK_EN
    logic r_fault;

    // Sticky fault on a misaligned redirect target; it also stops all further issue.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fault <= 1'b0;
        end else if (i_redirect && (i_redirect_pc[1:0] != 2'b00)) begin
            r_fault <= 1'b1;
        end
    end

    assign w_halt        = r_fault;
    assign o_fetch_fault = r_fault;
`else
    logic w_unused_pc_lsbs;

    assign w_unused_pc_lsbs = ^i_redirect_pc[1:0];
    assign w_halt           = 1'b0;
    assign o_fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_obsidian_fetch.sv
// tb/tb_obsidian_fetch.sv - scoreboard testbench for obsidian_fetch
`timescale 1ns/1ps

module tb_obsidian_fetch;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        o_imem_req;
    logic [15:0] o_imem_addr;
    logic [31:0] i_imem_rdata = 32'h0;
    logic [31:0] o_instruction;
    logic [15:0] o_instr_pc;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic        i_redirect;
    logic [15:0] i_redirect_pc;
    logic        o_fetch_fault;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q [$];

    obsidian_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_rdata  (i_imem_rdata),
        .o_instruction (o_instruction),
        .o_instr_pc    (o_instr_pc),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_fetch_fault (o_fetch_fault)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] word_at(input logic [15:0] a);
        case (a)
            16'h0000: word_at = 32'hD3400C22;
            16'h0004: word_at = 32'hD3433085;
            16'h0008: word_at = 32'hD342C0A7;
            default:  word_at = {16'hC0DE, a};
        endcase
    endfunction

    // Synchronous instruction memory: data one cycle after the strobe, junk otherwise.
    always @(posedge i_clk) begin
        i_imem_rdata <= o_imem_req ? word_at(o_imem_addr) : 32'hDEADBEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: every completed handshake must match the next expected PC and its word.
    always @(negedge i_clk) begin
        if (!i_reset && o_instr_valid && i_instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_instr actual_pc=%h expected=none t=%0t", o_instr_pc, $time);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("instr_pc", {16'h0, o_instr_pc}, {16'h0, e});
                chk("instruction", o_instruction, word_at(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        i_reset       = 1'b1;
        i_instr_ready = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 16'h0;
        cyc();
        cyc();
        @(negedge i_clk);
        chk("rst_imem_req", {31'h0, o_imem_req}, 32'h0);
        chk("rst_valid", {31'h0, o_instr_valid}, 32'h0);
        chk("rst_instruction", o_instruction, 32'h0);
        chk("rst_instr_pc", {16'h0, o_instr_pc}, 32'h0);
        chk("rst_fault", {31'h0, o_fetch_fault}, 32'h0);

        // Stream with decode always ready.
        cyc();
        i_reset = 1'b0;
        i_instr_ready = 1'b1;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0004);
        exp_q.push_back(16'h0008);
        @(negedge i_clk);
        chk("first_req", {31'h0, o_imem_req}, 32'h1);
        chk("first_addr", {16'h0, o_imem_addr}, 32'h0);
        chk("valid_c1", {31'h0, o_instr_valid}, 32'h0);
        cyc();
        @(negedge i_clk);
        chk("valid_c2", {31'h0, o_instr_valid}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge i_clk);
            chk("stream_valid", {31'h0, o_instr_valid}, 32'h1);
        end
        cyc();
        i_instr_ready = 1'b0;

        // Mid-stream reset, then backpressure from the start.
        cyc();
        i_reset = 1'b1;
        cyc();
        i_reset = 1'b0;
        cyc();
        cyc();
        cyc();
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            chk("bp_req", {31'h0, o_imem_req}, 32'h0);
            chk("bp_valid", {31'h0, o_instr_valid}, 32'h1);
            chk("bp_head", o_instruction, 32'hD3400C22);
            chk("bp_head_pc", {16'h0, o_instr_pc}, 32'h0);
            cyc();
        end
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0004);
        exp_q.push_back(16'h0008);
        i_instr_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        i_instr_ready = 1'b0;
        @(negedge i_clk);
        chk("bp2_req", {31'h0, o_imem_req}, 32'h0);
        cyc();

        // Redirect to 0x0040 while the read of 0x0014 is in flight.
        exp_q.push_back(16'h000C);
        exp_q.push_back(16'h0010);
        i_instr_ready = 1'b1;
        cyc();
        i_redirect    = 1'b1;
        i_redirect_pc = 16'h0040;
        @(negedge i_clk);
        chk("redir_req", {31'h0, o_imem_req}, 32'h0);
        cyc();
        i_redirect = 1'b0;
        exp_q.push_back(16'h0040);
        exp_q.push_back(16'h0044);
        exp_q.push_back(16'h0048);
        @(negedge i_clk);
        chk("redir_valid_n1", {31'h0, o_instr_valid}, 32'h0);
        chk("redir_req_n1", {31'h0, o_imem_req}, 32'h1);
        chk("redir_addr_n1", {16'h0, o_imem_addr}, 32'h0040);
        cyc();
        cyc();
        cyc();
        cyc();

        // Back-to-back redirects; the second (wrap region) wins.
        i_redirect    = 1'b1;
        i_redirect_pc = 16'h0080;
        cyc();
        i_redirect_pc = 16'hFFF8;
        exp_q.push_back(16'hFFF8);
        exp_q.push_back(16'hFFFC);
        exp_q.push_back(16'h0000);
        cyc();
        i_redirect = 1'b0;
        @(negedge i_clk);
        chk("wrap_addr", {16'h0, o_imem_addr}, 32'hFFF8);
        chk("wrap_valid", {31'h0, o_instr_valid}, 32'h0);
        cyc();
        cyc();
        cyc();
        cyc();
        cyc();
        i_instr_ready = 1'b0;

        // Misaligned redirect target.
        i_redirect    = 1'b1;
        i_redirect_pc = 16'h0042;
        cyc();
        i_redirect = 1'b0;
`ifdef OBSIDIAN_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk("align_fault", {31'h0, o_fetch_fault}, 32'h1);
            chk("align_req", {31'h0, o_imem_req}, 32'h0);
            chk("align_valid", {31'h0, o_instr_valid}, 32'h0);
            cyc();
        end
`else
        exp_q.push_back(16'h0040);
        @(negedge i_clk);
        chk("align_fault", {31'h0, o_fetch_fault}, 32'h0);
        chk("align_req", {31'h0, o_imem_req}, 32'h1);
        chk("align_addr", {16'h0, o_imem_addr}, 32'h0040);
        cyc();
        cyc();
        i_instr_ready = 1'b1;
        cyc();
        i_instr_ready = 1'b0;
`endif

        // Reset overrides a simultaneous redirect.
        cyc();
        i_reset       = 1'b1;
        i_redirect    = 1'b1;
        i_redirect_pc = 16'h0100;
        cyc();
        i_reset    = 1'b0;
        i_redirect = 1'b0;
        @(negedge i_clk);
        chk("rst2_valid", {31'h0, o_instr_valid}, 32'h0);
        chk("rst2_fault", {31'h0, o_fetch_fault}, 32'h0);
        chk("rst2_req", {31'h0, o_imem_req}, 32'h1);
        chk("rst2_addr", {16'h0, o_imem_addr}, 32'h0);
        for (int i = 0; i < 5; i++) cyc();
        chk("scoreboard_drained", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
